// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_pkg
// Description : Shared widths, load funct3 encodings and the load-tracker
//               state type for the writeback stage and its helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_load_align
// Description : Combinational load alignment. Selects the addressed byte or
//               halfword from a raw memory word and sign/zero extends it.
// Ports       : raw     in  XLEN  raw word from data memory
//               funct3  in  3     load type
//               addr_lo in  2     byte address bits [1:0]
//               ext     out XLEN  extended result
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = raw[{addr_lo, 3'b000} +: 8];
    // Halfwords are naturally aligned; the low address bit is ignored.
    w_half = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   ext = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, w_half};
      F3_LW:   ext = raw;
      default: ext = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Writeback stage. Merges the ALU result stream and the single
//               outstanding load response into one registered register-file
//               write per cycle, with a one-entry skid buffer for ALU results
//               that lose the port to a load response.
// Ports       : clk, rstn                       clock, async active-low reset
//               alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//               ld_issue/ld_issue_ready/ld_rd/ld_funct3/ld_addr_lo  load issue
//               ld_rvalid/ld_rdata              load response
//               rd/we/rwdata                    register-file write port
//               ld_busy/ld_busy_rd              load hazard information
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [REGW-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  output logic            ld_issue_ready,
  input  logic [REGW-1:0] ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic            ld_rvalid,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [REGW-1:0] rd,
  output logic            we,
  output logic [XLEN-1:0] rwdata,
  output logic            ld_busy,
  output logic [REGW-1:0] ld_busy_rd
);

  ld_state_t       r_state;
  logic [REGW-1:0] r_cap_rd;
  logic [2:0]      r_cap_f3;
  logic [1:0]      r_cap_lo;

  logic            r_skid_valid;
  logic [REGW-1:0] r_skid_rd;
  logic [XLEN-1:0] r_skid_data;
  // Output register currently holds the tracked load's write cycle.
  logic            r_out_load;

  logic            w_ld_take;
  logic            w_alu_acc;
  logic [XLEN-1:0] w_ld_ext;

  assign w_ld_take      = (r_state == WAIT) && ld_rvalid;
  assign alu_ready      = !r_skid_valid;
  assign w_alu_acc      = alu_valid && !r_skid_valid;
  assign ld_issue_ready = (r_state == IDLE);
  assign ld_busy        = (r_state == WAIT) || r_out_load;
  assign ld_busy_rd     = r_cap_rd;

  wb_stage_load_align u_align (
    .raw     (ld_rdata),
    .funct3  (r_cap_f3),
    .addr_lo (r_cap_lo),
    .ext     (w_ld_ext)
  );

  // Load tracker: one outstanding load, attributes captured at issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cap_rd <= '0;
      r_cap_f3 <= '0;
      r_cap_lo <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld_issue) begin
            r_state  <= WAIT;
            r_cap_rd <= ld_rd;
            r_cap_f3 <= ld_funct3;
            r_cap_lo <= ld_addr_lo;
          end
        end
        WAIT: begin
          if (ld_rvalid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write-port arbitration (load > skid > ALU), skid buffer and output regs.
  // rd/rwdata hold their last value when nothing is written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_skid_valid <= 1'b0;
      r_skid_rd    <= '0;
      r_skid_data  <= '0;
      r_out_load   <= 1'b0;
      rd           <= '0;
      we           <= 1'b0;
      rwdata       <= '0;
    end else begin
      r_out_load <= 1'b0;
      we         <= 1'b0;
      if (w_ld_take) begin
        rd         <= r_cap_rd;
        rwdata     <= w_ld_ext;
        we         <= (r_cap_rd != '0);
        r_out_load <= 1'b1;
        if (w_alu_acc) begin
          r_skid_valid <= 1'b1;
          r_skid_rd    <= alu_rd;
          r_skid_data  <= alu_data;
        end
      end else if (r_skid_valid) begin
        rd           <= r_skid_rd;
        rwdata       <= r_skid_data;
        we           <= (r_skid_rd != '0);
        r_skid_valid <= 1'b0;
      end else if (w_alu_acc) begin
        rd     <= alu_rd;
        rwdata <= alu_data;
        we     <= (alu_rd != '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Directed self-checking bench for wb_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk;
  logic        rstn;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic        ld_issue_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic [4:0]  rd;
  logic        we;
  logic [31:0] rwdata;
  logic        ld_busy;
  logic [4:0]  ld_busy_rd;

  int errors = 0;
  int checks = 0;

  wb_stage dut (
    .clk            (clk),
    .rstn           (rstn),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue       (ld_issue),
    .ld_issue_ready (ld_issue_ready),
    .ld_rd          (ld_rd),
    .ld_funct3      (ld_funct3),
    .ld_addr_lo     (ld_addr_lo),
    .ld_rvalid      (ld_rvalid),
    .ld_rdata       (ld_rdata),
    .rd             (rd),
    .we             (we),
    .rwdata         (rwdata),
    .ld_busy        (ld_busy),
    .ld_busy_rd     (ld_busy_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a load, return the word on the next cycle, check the write.
  task automatic do_load(input string tag, input logic [4:0] dst, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] word, input logic [31:0] exp);
    ld_issue = 1'b1; ld_rd = dst; ld_funct3 = f3; ld_addr_lo = lo;
    step();
    ld_issue = 1'b0;
    check({tag, "_busy"}, 32'(ld_busy), 32'd1);
    ld_rvalid = 1'b1; ld_rdata = word;
    step();
    ld_rvalid = 1'b0;
    check({tag, "_we"}, 32'(we), 32'(dst != 5'd0));
    check({tag, "_data"}, rwdata, exp);
    step();
    check({tag, "_busy_clr"}, 32'(ld_busy), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0;
    ld_rvalid = 1'b0; ld_rdata = '0;
    step(); step();
    check("rst_we", 32'(we), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_rwdata", rwdata, 32'd0);
    check("rst_busy", 32'(ld_busy), 32'd0);
    check("rst_busy_rd", 32'(ld_busy_rd), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_issue_ready", 32'(ld_issue_ready), 32'd1);
    rstn = 1'b1;
    step();

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    check("alu_we", 32'(we), 32'd1);
    check("alu_rd", 32'(rd), 32'd5);
    check("alu_data", rwdata, 32'hDEADBEEF);
    step();
    check("alu_we_drop", 32'(we), 32'd0);

    // Extension table
    do_load("lb1",  5'd1, 3'b000, 2'd1, 32'h1280FF34, 32'hFFFFFFFF);
    do_load("lbu0", 5'd2, 3'b100, 2'd0, 32'h1280FF34, 32'h00000034);
    do_load("lh2",  5'd3, 3'b001, 2'd2, 32'h1280FF34, 32'h00001280);
    do_load("lhu0", 5'd4, 3'b101, 2'd0, 32'h1280FF34, 32'h0000FF34);
    do_load("lw",   5'd6, 3'b010, 2'd3, 32'h1280FF34, 32'h1280FF34);
    do_load("lb3",  5'd8, 3'b000, 2'd3, 32'h7F000000, 32'h0000007F);

    // Collision: load x7 pending, ALU x9 arrives with the response
    ld_issue = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    step();
    ld_issue = 1'b0;
    step();
    ld_rvalid = 1'b1; ld_rdata = 32'hA5A5_0007;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h11;
    check("col_ready_n", 32'(alu_ready), 32'd1);
    step();
    ld_rvalid = 1'b0;
    alu_rd = 5'd10; alu_data = 32'h22;
    check("col_ld_we", 32'(we), 32'd1);
    check("col_ld_rd", 32'(rd), 32'd7);
    check("col_ld_data", rwdata, 32'hA5A50007);
    check("col_ready_n1", 32'(alu_ready), 32'd0);
    step();
    check("col_skid_we", 32'(we), 32'd1);
    check("col_skid_rd", 32'(rd), 32'd9);
    check("col_skid_data", rwdata, 32'h11);
    check("col_ready_n2", 32'(alu_ready), 32'd1);
    step();
    alu_valid = 1'b0;
    check("col_next_rd", 32'(rd), 32'd10);
    check("col_next_data", rwdata, 32'h22);
    step();
    check("col_idle_we", 32'(we), 32'd0);

    // x0 suppression
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    step();
    alu_valid = 1'b0;
    check("x0_alu_we", 32'(we), 32'd0);
    check("x0_alu_ready", 32'(alu_ready), 32'd1);
    do_load("x0_ld", 5'd0, 3'b010, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D);
    check("x0_ld_idle", 32'(ld_issue_ready), 32'd1);

    // Hazard flags and ignored second issue
    ld_issue = 1'b1; ld_rd = 5'd12; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    step();
    check("hz_busy", 32'(ld_busy), 32'd1);
    check("hz_busy_rd", 32'(ld_busy_rd), 32'd12);
    check("hz_issue_ready", 32'(ld_issue_ready), 32'd0);
    ld_rd = 5'd3; ld_funct3 = 3'b000;
    step();
    ld_issue = 1'b0;
    check("hz_ignore_rd", 32'(ld_busy_rd), 32'd12);
    check("hz_ignore_busy", 32'(ld_busy), 32'd1);
    ld_rvalid = 1'b1; ld_rdata = 32'h8000_0055;
    step();
    ld_rvalid = 1'b0;
    check("hz_wr_rd", 32'(rd), 32'd12);
    check("hz_wr_data", rwdata, 32'h80000055);
    check("hz_wr_busy", 32'(ld_busy), 32'd1);
    check("hz_wr_busy_rd", 32'(ld_busy_rd), 32'd12);
    step();
    check("hz_done_busy", 32'(ld_busy), 32'd0);

    // Reset mid-load, then a late response
    ld_issue = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b010;
    step();
    ld_issue = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    ld_rvalid = 1'b1; ld_rdata = 32'hFFFF_FFFF;
    step();
    ld_rvalid = 1'b0;
    check("mrst_we", 32'(we), 32'd0);
    check("mrst_rd", 32'(rd), 32'd0);
    check("mrst_rwdata", rwdata, 32'd0);
    check("mrst_busy", 32'(ld_busy), 32'd0);
    check("mrst_busy_rd", 32'(ld_busy_rd), 32'd0);
    check("mrst_issue_ready", 32'(ld_issue_ready), 32'd1);
    check("mrst_alu_ready", 32'(alu_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
